// File: rtl/hazard_ctrl_if.sv
// Operand-path control bundle between the ID/EX pipeline and the hazard controller.
interface hazard_ctrl_if;
  logic [15:0] id_instr;
  logic        id_valid;
  logic        flush;
  logic        mem_stall;
  logic [2:0]  ForwardA;
  logic [2:0]  ForwardB;
  logic        stall_fetch;
  logic        bubble_ex;
  logic        halted;

  // Pipeline side: presents the ID instruction and pipeline events, consumes selects.
  modport master (
    output id_instr, id_valid, flush, mem_stall,
    input  ForwardA, ForwardB, stall_fetch, bubble_ex, halted
  );

  // Controller side.
  modport slave (
    input  id_instr, id_valid, flush, mem_stall,
    output ForwardA, ForwardB, stall_fetch, bubble_ex, halted
  );
endinterface

// File: rtl/hazard_ctrl.sv
// EX-stage operand forwarding, load-use stall, flush squash and HLT drain sequencing.
// Keeps a shadow of the EX/MEM/WB destination state and derives mux selects from it.
module hazard_ctrl #(
  parameter int REG_W     = 4,
  parameter int DRAIN_CYC = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hif
);

  localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  localparam logic [2:0] FWD_MEM = 3'b010;
  localparam logic [2:0] FWD_WB  = 3'b001;
  localparam logic [2:0] FWD_RF  = 3'b000;

  typedef struct packed {
    logic             valid;
    logic             wr;
    logic [REG_W-1:0] dest;
    logic [REG_W-1:0] src_a;
    logic [REG_W-1:0] src_b;
    logic             use_a;
    logic             use_b;
    logic             is_load;
  } ex_t;

  typedef struct packed {
    logic             valid;
    logic             wr;
    logic [REG_W-1:0] dest;
    logic             is_load;
  } stg_t;

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  ex_t              ex_q, id_dec;
  stg_t             mem_q, wb_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]       op;
  logic [REG_W-1:0] f_rd, f_rs, f_rt;
  logic             wr_op, use_a_op, use_b_op, use_st_op, hlt_op;
  logic             lu;
  logic             sf_raw, bx_raw;

  assign op   = hif.id_instr[15:12];
  assign f_rd = REG_W'(hif.id_instr[11:8]);
  assign f_rs = REG_W'(hif.id_instr[7:4]);
  assign f_rt = REG_W'(hif.id_instr[3:0]);

  // Opcode classes; immediates (shifts, lw, sw) leave operand B unused.
  always_comb begin
    wr_op     = op inside {[4'h0:4'h8], 4'hA, 4'hB, 4'hE};
    use_a_op  = op inside {[4'h0:4'hB], 4'hD};
    use_b_op  = op inside {[4'h0:4'h3], 4'h7};
    use_st_op = (op == 4'h9);
    hlt_op    = (op == 4'hF);
  end

  // Decoded ID entry as it would land in EX; a write to R0 is not a write.
  always_comb begin
    id_dec         = '0;
    id_dec.valid   = hif.id_valid;
    id_dec.wr      = hif.id_valid & wr_op & (f_rd != '0);
    id_dec.dest    = f_rd;
    id_dec.src_a   = (op == 4'hA || op == 4'hB) ? f_rd : f_rs;
    id_dec.src_b   = f_rt;
    id_dec.use_a   = hif.id_valid & use_a_op;
    id_dec.use_b   = hif.id_valid & use_b_op;
    id_dec.is_load = hif.id_valid & (op == 4'h8);
  end

  // Load-use: a consumer in ID of a load in EX, including sw store data.
  always_comb begin
    lu = hif.id_valid & ex_q.is_load & ex_q.wr &
         ((use_a_op  && id_dec.src_a == ex_q.dest) ||
          (use_b_op  && f_rt         == ex_q.dest) ||
          (use_st_op && f_rd         == ex_q.dest));
  end

  // Drain FSM next-state and pipeline-control outputs, in priority order.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sf_raw  = 1'b0;
    bx_raw  = 1'b0;
    case (state_q)
      HALT: begin
        sf_raw = 1'b1;
        bx_raw = 1'b1;
      end
      DRAIN: begin
        sf_raw = 1'b1;
        bx_raw = 1'b1;
        if (!hif.mem_stall) begin
          if (cnt_q == '0) state_d = HALT;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      default: begin
        if (hif.mem_stall) begin
          sf_raw = 1'b1;
        end else if (hif.flush) begin
          bx_raw = 1'b1;
        end else if (lu) begin
          sf_raw = 1'b1;
          bx_raw = 1'b1;
        end else if (hif.id_valid && hlt_op) begin
          state_d = DRAIN;
          cnt_d   = CNT_W'(DRAIN_CYC - 1);
        end
      end
    endcase
  end

  // FSM state and drain counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Shadow stage registers; the whole pipe freezes while data memory is busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!hif.mem_stall) begin
      wb_q          <= mem_q;
      mem_q.valid   <= ex_q.valid;
      mem_q.wr      <= ex_q.wr;
      mem_q.dest    <= ex_q.dest;
      mem_q.is_load <= ex_q.is_load;
      ex_q          <= bx_raw ? '0 : id_dec;
    end
  end

  // Operand selects: MEM beats WB; a load in MEM never forwards (its data is not ready).
  always_comb begin
    hif.ForwardA = FWD_RF;
    if (ex_q.use_a && mem_q.valid && mem_q.wr && !mem_q.is_load && mem_q.dest == ex_q.src_a)
      hif.ForwardA = FWD_MEM;
    else if (ex_q.use_a && wb_q.valid && wb_q.wr && wb_q.dest == ex_q.src_a)
      hif.ForwardA = FWD_WB;

    hif.ForwardB = FWD_RF;
    if (ex_q.use_b && mem_q.valid && mem_q.wr && !mem_q.is_load && mem_q.dest == ex_q.src_b)
      hif.ForwardB = FWD_MEM;
    else if (ex_q.use_b && wb_q.valid && wb_q.wr && wb_q.dest == ex_q.src_b)
      hif.ForwardB = FWD_WB;
  end

  // Control outputs read as idle for the whole time reset is held.
  assign hif.stall_fetch = rst_n & sf_raw;
  assign hif.bubble_ex   = rst_n & bx_raw;
  assign hif.halted      = (state_q == HALT);

  // WB load flag is kept for visibility of the retiring instruction only.
  logic unused_wb;
  assign unused_wb = wb_q.is_load;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Sequencing controller for the EX-stage ALU operand path of the 5-stage pipeline.
- Decodes the ID-stage instruction and keeps a shadow copy of the EX/MEM/WB destination state.
- Drives the 3-bit ForwardA/ForwardB selects consumed by the ALU operand muxes.
- Issues load-use stalls, squashes wrong-path instructions on flush, and sequences HLT drain to a sticky halted state.

Parameters:
- REG_W, 4, register-specifier width (16 GPRs; R0 reads as zero and is never forwarded).
- DRAIN_CYC, 3, cycles from HLT leaving ID until `halted` asserts (HLT passes EX, MEM, WB).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_instr  in  16  instruction currently in the IF/ID register.
- id_valid  in  1  id_instr is a real instruction, not a bubble.
- flush  in  1  branch taken this cycle; the ID instruction is wrong-path.
- mem_stall  in  1  data memory busy; freezes the whole pipeline.
- ForwardA  out  3  EX operand-A select: 3'b010 = MEM ALU result, 3'b001 = WB write data, 3'b000 = register file; bit 2 is always 0.
- ForwardB  out  3  same encoding for operand B.
- stall_fetch  out  1  hold PC and IF/ID.
- bubble_ex  out  1  load a NOP into ID/EX this cycle.
- halted  out  1  processor stopped.

Behaviour:
- Decode uses opcode = id_instr[15:12]. Field [11:8] is rd; [7:4] is rs; [3:0] is rt.
- Write-register instructions: opcodes 0000–1000, 1010, 1011, 1110. For lw the destination is [11:8]. Any write with dest == 0 counts as no write.
- Source A:
  - [7:4] for 0000–1001 and 1101.
  - [11:8] for lhb/llb (1010/1011).
  - None for 1100, 1110, 1111.
- Source B: [3:0] for 0000–0011 and 0111; none otherwise. Shifts, lw and sw use an immediate for B.
- sw store data [11:8] is a hazard source for the stall check only.
- is_load = (opcode == 1000).
- State held per stage:
  - EX: valid, wr, dest, srcA, srcB, useA, useB, is_load.
  - MEM and WB: valid, wr, dest, is_load.
- Stage advance occurs on each clock with mem_stall = 0:
  - WB takes MEM.
  - MEM takes EX.
  - EX takes decoded ID, or all-zero (bubble) when bubble_ex = 1.
- With mem_stall = 1, all stage registers and the drain counter hold.
- Forwarding is combinational from registered EX/MEM/WB state.
  - ForwardA = 010 if EX.useA and MEM.wr and MEM.dest == EX.srcA.
  - Otherwise ForwardA = 001 if EX.useA and WB.wr and WB.dest == EX.srcA.
  - Otherwise ForwardA = 000.
  - MEM has priority over WB.
  - A MEM-stage load is never a forward source; the load-use stall guarantees this case does not arise. If the bench finds MEM.is_load matching, that is an assertion failure.
  - ForwardB follows the same rules using srcB/useB.
- Load-use hazard: lu = id_valid & EX.is_load & EX.wr & (ID source A, source B or store data == EX.dest).
  - The stall lasts exactly 1 cycle.
  - Next cycle the consumer sees a bubble in EX and the load in MEM. It then advances with the load in WB, giving ForwardX = 001.
- Outputs, evaluated in priority order:
  - halted: stall_fetch = 1, bubble_ex = 1.
  - DRAIN state: stall_fetch = 1, bubble_ex = 1.
  - mem_stall: stall_fetch = 1, bubble_ex = 0 (hold).
  - flush: stall_fetch = 0, bubble_ex = 1. flush overrides lu and HLT decode.
  - lu: stall_fetch = 1, bubble_ex = 1.
  - hlt decoded (id_valid, opcode 1111): HLT enters EX this edge; next state DRAIN; counter = DRAIN_CYC-1.
- FSM:
  - RUN → DRAIN on HLT advance.
  - DRAIN: the counter decrements on each non-mem_stall clock. At 0 the state moves to HALT.
  - HALT is sticky until rst_n.
  - halted = 1 only in HALT.
- Reset (asynchronous, mid-operation included) clears:
  - all stage valid/wr bits;
  - FSM = RUN, counter = 0;
  - ForwardA = ForwardB = 000, stall_fetch = 0, bubble_ex = 0, halted = 0.
- Reset release is taken at the next rising edge.

Test Plan:
- add R1,R2,R3 then add R4,R1,R5 back-to-back: with the second in EX, ForwardA = 010, ForwardB = 000. With a one-instruction gap, ForwardA = 001.
- add R1 in MEM and sub R1 in WB, consumer xor R6,R1,R1 in EX: ForwardA = ForwardB = 010 (MEM priority).
- lw R2,0(R3) then add R4,R2,R2: one cycle of stall_fetch = 1 and bubble_ex = 1, then the add executes with ForwardA = ForwardB = 001. Total 1 lost cycle.
- Write to R0 followed by a reader of R0: ForwardA = 000 and no stall. lw into R0 followed by a reader: no stall.
- Load-use condition with flush = 1 in the same cycle: bubble_ex = 1, stall_fetch = 0, no extra stall cycle. Repeat with mem_stall = 1 held 4 cycles mid-sequence: stage state is unchanged and Forward outputs are stable throughout.
- hlt in ID with id_valid: halted rises exactly 3 non-stalled clocks after HLT enters EX and stays 1. rst_n pulsed low during DRAIN drops all outputs to 0 immediately, and RUN resumes.
